// File: rtl/serdes_tx_scheduler_if.sv
// rtl/serdes_tx_scheduler_if.sv - word-source handshake and serial output bundle
interface serdes_tx_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              gnt0;
  logic              gnt1;
  logic              busy;
  logic              done;
  logic              ser_out;

  // Word sources drive requests and data; the scheduler answers with grants and the line
  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, busy, done, ser_out
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, busy, done, ser_out
  );
endinterface

// File: rtl/serdes_tx_scheduler.sv
// rtl/serdes_tx_scheduler.sv - round-robin word arbiter and framed serializer
module serdes_tx_scheduler #(
  parameter int DATA_W    = 8,
  parameter int BIT_DIV   = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  serdes_tx_scheduler_if.slave   bus
);
  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LP_CNT_MAX = CW'(BIT_DIV - 1);
  localparam logic [IW-1:0] LP_IDX_MAX = IW'(DATA_W - 1);
  localparam bit LP_PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_par, w_par_nxt;
  logic              r_last, w_last_nxt;
  logic              r_gnt0, w_gnt0_nxt;
  logic              r_gnt1, w_gnt1_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ser, w_ser_nxt;
  logic              w_bit_end;
  logic              w_pick1;

  assign w_bit_end = (r_cnt == LP_CNT_MAX);
  // Requester 1 wins when alone, or in contention when requester 0 was served last
  assign w_pick1   = bus.req1 && (!bus.req0 || !r_last);

  // State register; every output is a flop so ser_out cannot glitch
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ser   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_last  <= w_last_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ser   <= w_ser_nxt;
    end
  end

  // Next state plus the output values that will be visible in the next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_last_nxt  = r_last;
    w_gnt0_nxt  = 1'b0;
    w_gnt1_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_ser_nxt   = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (bus.req0 || bus.req1) begin
          w_state_nxt = START;
          w_last_nxt  = w_pick1;
          w_gnt0_nxt  = !w_pick1;
          w_gnt1_nxt  = w_pick1;
          w_shift_nxt = w_pick1 ? bus.data1 : bus.data0;
          w_par_nxt   = w_pick1 ? ^bus.data1 : ^bus.data0;
          w_ser_nxt   = 1'b0;
        end
      end
      START: begin
        w_ser_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_ser_nxt   = r_shift[0];
        end
      end
      DATA: begin
        w_ser_nxt = r_shift[0];
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          w_idx_nxt   = r_idx + 1'b1;
          if (r_idx == LP_IDX_MAX) begin
            w_state_nxt = LP_PAR ? PARITY : STOP;
            w_ser_nxt   = LP_PAR ? r_par : 1'b1;
          end else begin
            w_ser_nxt = w_shift_nxt[0];
          end
        end
      end
      PARITY: begin
        w_ser_nxt = r_par;
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_cnt_nxt   = '0;
          w_ser_nxt   = 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ser_out = r_ser;
endmodule
